// File: rtl/multichan_accumulate.sv
// Multi-channel accumulator: NUM_CHAN running sums sharing one add/sub datapath,
// with optional saturation, per-channel sticky overflow and a delayed result pipeline.
module multichan_accumulate #(
  parameter int    WIDTH_IN       = 4,
  parameter int    WIDTH_OUT      = 8,
  parameter int    NUM_CHAN       = 4,
  parameter int    CHAN_W         = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1,
  parameter string REPRESENTATION = "UNSIGNED",
  parameter int    SATURATE       = 0,
  parameter int    EXTRA_LATENCY  = 0
) (
  input  logic                 clock,
  input  logic                 sclr,
  input  logic                 clken,
  input  logic                 in_valid,
  input  logic [CHAN_W-1:0]    in_chan,
  input  logic [WIDTH_IN-1:0]  data,
  input  logic                 add_sub,
  input  logic                 sload,
  output logic                 out_valid,
  output logic [CHAN_W-1:0]    out_chan,
  output logic [WIDTH_OUT-1:0] result,
  output logic                 cout,
  output logic                 overflow,
  output logic [NUM_CHAN-1:0]  ovf_sticky
);

  localparam bit IS_SIGNED = (REPRESENTATION == "SIGNED");
  localparam int DEPTH     = EXTRA_LATENCY + 1;
  localparam int MSB       = WIDTH_OUT - 1;

  logic [WIDTH_OUT-1:0] acc_mem [NUM_CHAN];
  logic [NUM_CHAN-1:0]  sticky;

  logic                 pipe_valid  [DEPTH];
  logic [CHAN_W-1:0]    pipe_chan   [DEPTH];
  logic [WIDTH_OUT-1:0] pipe_result [DEPTH];
  logic                 pipe_cout   [DEPTH];
  logic                 pipe_ovf    [DEPTH];

  logic                 accept;
  logic                 chan_ok;
  logic [WIDTH_OUT-1:0] ext;
  logic [WIDTH_OUT-1:0] acc;
  logic [WIDTH_OUT:0]   raw;
  logic [WIDTH_OUT-1:0] smin;
  logic [WIDTH_OUT-1:0] sat_val;
  logic [WIDTH_OUT-1:0] new_val;
  logic                 op_cout;
  logic                 op_ovf;

  assign accept  = clken & in_valid & ~sclr;
  assign chan_ok = (int'(in_chan) < NUM_CHAN);
  assign ext     = IS_SIGNED ? WIDTH_OUT'($signed(data)) : WIDTH_OUT'(data);
  assign acc     = chan_ok ? acc_mem[in_chan] : '0;

  // Single shared datapath; sload and out-of-range channels override the arithmetic
  always_comb begin
    raw     = add_sub ? ({1'b0, acc} + {1'b0, ext}) : ({1'b0, acc} - {1'b0, ext});
    op_cout = add_sub ? raw[WIDTH_OUT] : (acc >= ext);
    if (IS_SIGNED) begin
      op_ovf = add_sub ? ((acc[MSB] == ext[MSB]) && (raw[MSB] != acc[MSB]))
                       : ((acc[MSB] != ext[MSB]) && (raw[MSB] != acc[MSB]));
    end else begin
      op_ovf = add_sub ? op_cout : ~op_cout;
    end
    smin      = '0;
    smin[MSB] = 1'b1;
    if (IS_SIGNED) begin
      sat_val = acc[MSB] ? smin : ~smin;
    end else begin
      sat_val = add_sub ? '1 : '0;
    end
    new_val = ((SATURATE != 0) && op_ovf) ? sat_val : raw[WIDTH_OUT-1:0];
    if (sload) begin
      new_val = ext;
      op_cout = 1'b0;
      op_ovf  = 1'b0;
    end
    if (!chan_ok) begin
      new_val = '0;
      op_cout = 1'b0;
      op_ovf  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      for (int c = 0; c < NUM_CHAN; c++) acc_mem[c] <= '0;
      sticky <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        pipe_valid[s]  <= 1'b0;
        pipe_chan[s]   <= '0;
        pipe_result[s] <= '0;
        pipe_cout[s]   <= 1'b0;
        pipe_ovf[s]    <= 1'b0;
      end
    end else if (clken) begin
      if (accept && chan_ok) begin
        acc_mem[in_chan] <= new_val;
        if (sload) sticky[in_chan] <= 1'b0;
        else if (op_ovf) sticky[in_chan] <= 1'b1;
      end
      pipe_valid[0]  <= accept;
      pipe_chan[0]   <= in_chan;
      pipe_result[0] <= new_val;
      pipe_cout[0]   <= op_cout;
      pipe_ovf[0]    <= op_ovf;
      for (int s = 1; s < DEPTH; s++) begin
        pipe_valid[s]  <= pipe_valid[s-1];
        pipe_chan[s]   <= pipe_chan[s-1];
        pipe_result[s] <= pipe_result[s-1];
        pipe_cout[s]   <= pipe_cout[s-1];
        pipe_ovf[s]    <= pipe_ovf[s-1];
      end
    end
  end

  assign out_valid  = pipe_valid[DEPTH-1];
  assign out_chan   = pipe_chan[DEPTH-1];
  assign result     = pipe_result[DEPTH-1];
  assign cout       = pipe_cout[DEPTH-1];
  assign overflow   = pipe_ovf[DEPTH-1];
  assign ovf_sticky = sticky;

endmodule

// File: tb/tb_multichan_accumulate.sv
// Bench for multichan_accumulate: six configurations driven in lockstep and
// compared every cycle against an arithmetic reference model.
module tb_multichan_accumulate;

  localparam int NINST = 6;
  localparam int SGN [NINST] = '{0, 0, 1, 1, 0, 0};
  localparam int SAT [NINST] = '{0, 1, 0, 1, 0, 1};
  localparam int LAT [NINST] = '{0, 0, 0, 0, 2, 1};
  localparam int NCH [NINST] = '{4, 4, 4, 4, 4, 3};

  typedef struct {
    int due;
    int chan;
    int res;
    bit cout;
    bit ovf;
    bit valid;
  } exp_t;

  logic       clock = 1'b0;
  logic       sclr = 1'b1;
  logic       clken = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] in_chan = '0;
  logic [3:0] data = '0;
  logic       add_sub = 1'b1;
  logic       sload = 1'b0;

  logic       ov_w  [NINST];
  logic [1:0] oc_w  [NINST];
  logic [7:0] res_w [NINST];
  logic       co_w  [NINST];
  logic       of_w  [NINST];
  logic [3:0] stk_w [NINST];

  int   checks = 0;
  int   errors = 0;
  int   en_cyc = 0;
  int   macc [NINST][4];
  bit   mstk [NINST][4];
  exp_t q    [NINST][$];
  exp_t last [NINST];

  always #5 clock = ~clock;

  for (genvar g = 0; g < NINST; g++) begin : g_dut
    localparam string REP = (SGN[g] != 0) ? "SIGNED" : "UNSIGNED";
    logic [NCH[g]-1:0] stk_local;
    multichan_accumulate #(
      .WIDTH_IN(4), .WIDTH_OUT(8), .NUM_CHAN(NCH[g]), .REPRESENTATION(REP),
      .SATURATE(SAT[g]), .EXTRA_LATENCY(LAT[g])
    ) u_dut (
      .clock(clock), .sclr(sclr), .clken(clken), .in_valid(in_valid),
      .in_chan(in_chan), .data(data), .add_sub(add_sub), .sload(sload),
      .out_valid(ov_w[g]), .out_chan(oc_w[g]), .result(res_w[g]),
      .cout(co_w[g]), .overflow(of_w[g]), .ovf_sticky(stk_local)
    );
    assign stk_w[g] = 4'(stk_local);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference arithmetic on plain integers: true sums, range tests and clamps
  function automatic exp_t model_op(int k, int chan, int d, bit as, bit sl);
    exp_t e;
    int a, eu, sa, se, t, wrap, satv;
    e = '{default: 0};
    e.chan = chan;
    e.valid = 1'b1;
    if (chan >= NCH[k]) return e;
    a  = macc[k][chan];
    eu = (SGN[k] != 0 && d >= 8) ? d + 240 : d;
    if (sl) begin
      macc[k][chan] = eu;
      mstk[k][chan] = 1'b0;
      e.res = eu;
      return e;
    end
    e.cout = as ? ((a + eu) > 255) : (a >= eu);
    if (SGN[k] == 0) begin
      e.ovf = as ? e.cout : !e.cout;
      wrap  = as ? (a + eu) % 256 : (a - eu + 256) % 256;
      satv  = as ? 255 : 0;
    end else begin
      sa    = (a >= 128) ? a - 256 : a;
      se    = (eu >= 128) ? eu - 256 : eu;
      t     = as ? sa + se : sa - se;
      e.ovf = (t > 127) || (t < -128);
      wrap  = t & 255;
      satv  = (t > 127) ? 127 : 128;
    end
    e.res = (SAT[k] != 0 && e.ovf) ? satv : wrap;
    macc[k][chan] = e.res;
    if (e.ovf) mstk[k][chan] = 1'b1;
    return e;
  endfunction

  task automatic applyStimulus(input bit v, input int chan, input int d, input bit as,
                               input bit sl, input bit ce, input bit rst);
    exp_t e;
    logic [3:0] sv;
    in_valid = v;
    in_chan  = chan[1:0];
    data     = d[3:0];
    add_sub  = as;
    sload    = sl;
    clken    = ce;
    sclr     = rst;
    @(posedge clock);
    if (rst) begin
      for (int k = 0; k < NINST; k++) begin
        for (int c = 0; c < 4; c++) begin
          macc[k][c] = 0;
          mstk[k][c] = 1'b0;
        end
        q[k].delete();
        last[k] = '{default: 0};
      end
    end else if (ce) begin
      en_cyc++;
      if (v) begin
        for (int k = 0; k < NINST; k++) begin
          e = model_op(k, chan, d, as, sl);
          e.due = en_cyc + LAT[k];
          q[k].push_back(e);
        end
      end
    end
    #1;
    for (int k = 0; k < NINST; k++) begin
      if (!rst && ce) begin
        if (q[k].size() > 0 && q[k][0].due == en_cyc) last[k] = q[k].pop_front();
        else last[k].valid = 1'b0;
      end
      checkOutput($sformatf("out_valid[%0d]", k), 32'(ov_w[k]), 32'(last[k].valid));
      if (rst || last[k].valid) begin
        checkOutput($sformatf("out_chan[%0d]", k), 32'(oc_w[k]), last[k].chan);
        checkOutput($sformatf("result[%0d]", k), 32'(res_w[k]), last[k].res);
        checkOutput($sformatf("cout[%0d]", k), 32'(co_w[k]), 32'(last[k].cout));
        checkOutput($sformatf("overflow[%0d]", k), 32'(of_w[k]), 32'(last[k].ovf));
      end
      for (int c = 0; c < 4; c++) sv[c] = mstk[k][c];
      checkOutput($sformatf("ovf_sticky[%0d]", k), 32'(stk_w[k]), 32'(sv));
    end
  endtask

  initial begin
    for (int k = 0; k < NINST; k++) last[k] = '{default: 0};

    // Reset state
    applyStimulus(0, 0, 0, 1, 0, 1, 1);
    applyStimulus(0, 0, 0, 1, 0, 0, 1);
    checkOutput("reset_result", 32'(res_w[4]), 0);

    // Load and add on channel 0
    applyStimulus(1, 0, 5, 1, 1, 1, 0);
    checkOutput("t1_load", 32'(res_w[0]), 5);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 3, 1, 0, 1, 0);
    checkOutput("t1_sum", 32'(res_w[0]), 14);

    // Interleaved channels
    applyStimulus(1, 1, 1, 1, 0, 1, 0);
    applyStimulus(1, 2, 2, 1, 0, 1, 0);
    applyStimulus(1, 1, 1, 1, 0, 1, 0);
    checkOutput("t2_ch1", 32'(res_w[0]), 2);
    applyStimulus(1, 2, 2, 1, 0, 1, 0);
    checkOutput("t2_ch2", 32'(res_w[0]), 4);
    checkOutput("t2_chan", 32'(oc_w[0]), 2);

    // Build 0xFE on ch0 then add 3: wrap vs saturate, then sload clears sticky
    applyStimulus(1, 0, 15, 1, 1, 1, 0);
    for (int i = 0; i < 15; i++) applyStimulus(1, 0, 15, 1, 0, 1, 0);
    applyStimulus(1, 0, 14, 1, 0, 1, 0);
    checkOutput("t3_pre", 32'(res_w[0]), 8'hFE);
    applyStimulus(1, 0, 3, 1, 0, 1, 0);
    checkOutput("t3_wrap", 32'(res_w[0]), 8'h01);
    checkOutput("t3_sat", 32'(res_w[1]), 8'hFF);
    checkOutput("t3_sticky", 32'(stk_w[0][0]), 1);
    applyStimulus(1, 0, 0, 1, 1, 1, 0);
    checkOutput("t3_clear", 32'(stk_w[0][0]), 0);

    // Unsigned subtract below zero on ch3
    applyStimulus(1, 3, 2, 1, 1, 1, 0);
    applyStimulus(1, 3, 3, 0, 0, 1, 0);
    checkOutput("t4_wrap", 32'(res_w[0]), 8'hFF);
    checkOutput("t4_sat", 32'(res_w[1]), 8'h00);
    checkOutput("t4_ovf", 32'(of_w[0]), 1);

    // Signed positive overflow from 0x7C
    applyStimulus(1, 0, 7, 1, 1, 1, 0);
    for (int i = 0; i < 16; i++) applyStimulus(1, 0, 7, 1, 0, 1, 0);
    applyStimulus(1, 0, 5, 1, 0, 1, 0);
    checkOutput("t5a_pre", 32'(res_w[2]), 8'h7C);
    applyStimulus(1, 0, 7, 1, 0, 1, 0);
    checkOutput("t5a_wrap", 32'(res_w[2]), 8'h83);
    checkOutput("t5a_sat", 32'(res_w[3]), 8'h7F);

    // Signed negative overflow from 0x82
    applyStimulus(1, 0, 8, 1, 1, 1, 0);
    for (int i = 0; i < 14; i++) applyStimulus(1, 0, 8, 1, 0, 1, 0);
    applyStimulus(1, 0, 10, 1, 0, 1, 0);
    checkOutput("t5b_pre", 32'(res_w[2]), 8'h82);
    applyStimulus(1, 0, 8, 1, 0, 1, 0);
    checkOutput("t5b_wrap", 32'(res_w[2]), 8'h7A);
    checkOutput("t5b_sat", 32'(res_w[3]), 8'h80);
    checkOutput("t5b_ovf", 32'(of_w[2]), 1);

    // Latency, stall and reset with ops in flight
    applyStimulus(0, 0, 0, 1, 0, 1, 1);
    applyStimulus(1, 0, 1, 1, 0, 1, 0);
    applyStimulus(1, 0, 1, 1, 0, 1, 0);
    applyStimulus(1, 0, 1, 1, 0, 1, 0);
    checkOutput("t6_first", 32'(res_w[4]), 1);
    applyStimulus(1, 0, 1, 1, 0, 0, 0);
    applyStimulus(1, 0, 1, 1, 0, 0, 0);
    checkOutput("t6_held", 32'(res_w[4]), 1);
    applyStimulus(0, 0, 0, 1, 0, 1, 0);
    checkOutput("t6_second", 32'(res_w[4]), 2);
    applyStimulus(1, 1, 1, 1, 0, 1, 1);
    checkOutput("t6_rst_valid", 32'(ov_w[4]), 0);
    applyStimulus(0, 0, 0, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0, 1, 0);
    applyStimulus(1, 0, 1, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0, 1, 0);
    checkOutput("t6_after", 32'(res_w[4]), 1);
    checkOutput("t6_after_valid", 32'(ov_w[4]), 1);

    // Randomized traffic, including stalls, resets and out-of-range channels
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 4) != 0, $urandom % 4, $urandom % 16, $urandom % 2,
                    ($urandom % 8) == 0, ($urandom % 5) != 0, ($urandom % 64) == 0);
    end
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
